load_store_queue: RTL and testbench

Parametrised successor to the current load/store buffer: an in-order circular queue of memory operations between the decoder, the reorder buffer (ROB) and the data cache. Entries capture operands from `NUM_WB` write-back broadcast channels. The queue issues one memory request at a time and can issue back-to-back. It supports a pipeline flush that discards speculative entries and drains any in-flight transaction safely.

---
 rtl/load_store_queue.sv | 263 ++++++++++++++++++++++++++
 tb/tb_load_store_queue.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_queue.sv
// In-order circular load/store queue: captures operands from write-back broadcasts
// and issues one data-cache request at a time, with back-to-back issue and flush drain.
module load_store_queue #(
    parameter int         LSQ_SIZE_BIT = 3,
    parameter int         ROB_BIT      = 4,
    parameter int         NUM_WB       = 2,
    parameter logic [1:0] IO_TAG       = 2'b11
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    input  logic                      inst_valid,
    input  logic [3:0]                inst_type,
    input  logic [31:0]               inst_r1,
    input  logic [31:0]               inst_r2,
    input  logic [ROB_BIT-1:0]        inst_dep1,
    input  logic [ROB_BIT-1:0]        inst_dep2,
    input  logic                      inst_has_dep1,
    input  logic                      inst_has_dep2,
    input  logic [11:0]               inst_offset,
    input  logic [ROB_BIT-1:0]        inst_rob_id,
    output logic                      full,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*ROB_BIT-1:0] wb_rob_id,
    input  logic [NUM_WB*32-1:0]      wb_value,
    input  logic                      rob_empty,
    input  logic [ROB_BIT-1:0]        rob_head_id,
    output logic                      mem_valid,
    output logic                      mem_wr,
    output logic [2:0]                mem_size,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic                      mem_ready,
    input  logic [31:0]               mem_rdata,
    output logic                      out_valid,
    output logic [ROB_BIT-1:0]        out_rob_id,
    output logic [31:0]               out_value
);

    localparam int SIZE = 1 << LSQ_SIZE_BIT;
    localparam int PW   = LSQ_SIZE_BIT;
    localparam int CW   = LSQ_SIZE_BIT + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    logic               busy_q     [SIZE];
    logic               busy_d     [SIZE];
    logic [ROB_BIT-1:0] rob_id_q   [SIZE];
    logic [ROB_BIT-1:0] rob_id_d   [SIZE];
    logic [3:0]         type_q     [SIZE];
    logic [3:0]         type_d     [SIZE];
    logic [31:0]        r1_q       [SIZE];
    logic [31:0]        r1_d       [SIZE];
    logic [31:0]        r2_q       [SIZE];
    logic [31:0]        r2_d       [SIZE];
    logic [ROB_BIT-1:0] dep1_q     [SIZE];
    logic [ROB_BIT-1:0] dep1_d     [SIZE];
    logic [ROB_BIT-1:0] dep2_q     [SIZE];
    logic [ROB_BIT-1:0] dep2_d     [SIZE];
    logic               has_dep1_q [SIZE];
    logic               has_dep1_d [SIZE];
    logic               has_dep2_q [SIZE];
    logic               has_dep2_d [SIZE];
    logic [11:0]        offset_q   [SIZE];
    logic [11:0]        offset_d   [SIZE];

    logic [PW-1:0]      head_q, head_d, tail_q, tail_d, head_nxt, issue_idx;
    logic [CW-1:0]      count_q, count_d;
    logic               full_q, full_d;
    state_t             state_q, state_d;
    logic               mem_valid_q, mem_valid_d, mem_wr_q, mem_wr_d;
    logic [2:0]         mem_size_q, mem_size_d;
    logic [31:0]        mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [ROB_BIT-1:0] cur_rob_q, cur_rob_d;
    logic               alloc, pop, do_issue;
    logic [SIZE-1:0]    elig;
    logic [31:0]        addr_e     [SIZE];

    assign head_nxt = head_q + PW'(1);
    assign alloc    = inst_valid && !flush_in;

    always_comb begin
        for (int unsigned i = 0; i < SIZE; i++) begin
            addr_e[i] = r1_q[i] + {{20{offset_q[i][11]}}, offset_q[i]};
            elig[i]   = busy_q[i] && !has_dep1_q[i] && !has_dep2_q[i] &&
                        ((!type_q[i][3] && addr_e[i][17:16] != IO_TAG) ||
                         (!rob_empty && rob_head_id == rob_id_q[i]));
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_wr_d    = mem_wr_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cur_rob_d   = cur_rob_q;
        pop         = 1'b0;
        do_issue    = 1'b0;
        issue_idx   = head_q;
        case (state_q)
            IDLE: if (!flush_in && elig[head_q]) begin
                do_issue = 1'b1;
                state_d  = BUSY;
            end
            BUSY: begin
                // a flush completing in the same cycle has nothing left to drain
                if (flush_in) begin
                    state_d = mem_ready ? IDLE : DRAIN;
                end else if (mem_ready) begin
                    pop = 1'b1;
                    if (elig[head_nxt]) begin
                        do_issue  = 1'b1;
                        issue_idx = head_nxt;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN:   if (mem_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (do_issue) begin
            mem_wr_d    = type_q[issue_idx][3];
            mem_size_d  = type_q[issue_idx][2:0];
            mem_addr_d  = addr_e[issue_idx];
            mem_wdata_d = r2_q[issue_idx];
            cur_rob_d   = rob_id_q[issue_idx];
        end
        mem_valid_d = (state_d != IDLE);
    end

    always_comb begin
        for (int unsigned i = 0; i < SIZE; i++) begin
            busy_d[i]     = busy_q[i];
            rob_id_d[i]   = rob_id_q[i];
            type_d[i]     = type_q[i];
            r1_d[i]       = r1_q[i];
            r2_d[i]       = r2_q[i];
            dep1_d[i]     = dep1_q[i];
            dep2_d[i]     = dep2_q[i];
            has_dep1_d[i] = has_dep1_q[i];
            has_dep2_d[i] = has_dep2_q[i];
            offset_d[i]   = offset_q[i];
            for (int unsigned c = 0; c < NUM_WB; c++) begin
                if (busy_q[i] && wb_valid[c]) begin
                    if (has_dep1_q[i] && wb_rob_id[c*ROB_BIT +: ROB_BIT] == dep1_q[i]) begin
                        r1_d[i]       = wb_value[c*32 +: 32];
                        has_dep1_d[i] = 1'b0;
                    end
                    if (has_dep2_q[i] && wb_rob_id[c*ROB_BIT +: ROB_BIT] == dep2_q[i]) begin
                        r2_d[i]       = wb_value[c*32 +: 32];
                        has_dep2_d[i] = 1'b0;
                    end
                end
            end
        end
        if (pop) busy_d[head_q] = 1'b0;
        // allocation after pop: at wrap-around the freshly popped slot may be reused
        if (alloc) begin
            busy_d[tail_q]     = 1'b1;
            rob_id_d[tail_q]   = inst_rob_id;
            type_d[tail_q]     = inst_type;
            r1_d[tail_q]       = inst_r1;
            r2_d[tail_q]       = inst_r2;
            dep1_d[tail_q]     = inst_dep1;
            dep2_d[tail_q]     = inst_dep2;
            has_dep1_d[tail_q] = inst_has_dep1;
            has_dep2_d[tail_q] = inst_has_dep2;
            offset_d[tail_q]   = inst_offset;
            for (int unsigned c = 0; c < NUM_WB; c++) begin
                if (wb_valid[c] && inst_has_dep1 && wb_rob_id[c*ROB_BIT +: ROB_BIT] == inst_dep1) begin
                    r1_d[tail_q]       = wb_value[c*32 +: 32];
                    has_dep1_d[tail_q] = 1'b0;
                end
                if (wb_valid[c] && inst_has_dep2 && wb_rob_id[c*ROB_BIT +: ROB_BIT] == inst_dep2) begin
                    r2_d[tail_q]       = wb_value[c*32 +: 32];
                    has_dep2_d[tail_q] = 1'b0;
                end
            end
        end
        head_d  = pop   ? head_nxt : head_q;
        tail_d  = alloc ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(alloc) - CW'(pop);
        if (flush_in) begin
            for (int unsigned i = 0; i < SIZE; i++) busy_d[i] = 1'b0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
        full_d = (count_d >= CW'(SIZE - 1));
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                busy_q[i]     <= 1'b0;
                rob_id_q[i]   <= '0;
                type_q[i]     <= '0;
                r1_q[i]       <= '0;
                r2_q[i]       <= '0;
                dep1_q[i]     <= '0;
                dep2_q[i]     <= '0;
                has_dep1_q[i] <= 1'b0;
                has_dep2_q[i] <= 1'b0;
                offset_q[i]   <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else if (rdy_in) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                busy_q[i]     <= busy_d[i];
                rob_id_q[i]   <= rob_id_d[i];
                type_q[i]     <= type_d[i];
                r1_q[i]       <= r1_d[i];
                r2_q[i]       <= r2_d[i];
                dep1_q[i]     <= dep1_d[i];
                dep2_q[i]     <= dep2_d[i];
                has_dep1_q[i] <= has_dep1_d[i];
                has_dep2_q[i] <= has_dep2_d[i];
                offset_q[i]   <= offset_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_size_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cur_rob_q   <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_wr_q    <= mem_wr_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cur_rob_q   <= cur_rob_d;
        end
    end

    assign full       = full_q;
    assign mem_valid  = mem_valid_q;
    assign mem_wr     = mem_wr_q;
    assign mem_size   = mem_size_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign out_valid  = (state_q == BUSY) && mem_ready && rdy_in && !flush_in;
    assign out_rob_id = cur_rob_q;
    assign out_value  = mem_wr_q ? '0 : mem_rdata;

endmodule

// File: tb/tb_load_store_queue.sv
// Directed self-checking bench for load_store_queue with hand-computed expectations.
module tb_load_store_queue;

    logic        clk_in, rst_in, rdy_in, flush_in;
    logic        inst_valid;
    logic [3:0]  inst_type;
    logic [31:0] inst_r1, inst_r2;
    logic [3:0]  inst_dep1, inst_dep2, inst_rob_id;
    logic        inst_has_dep1, inst_has_dep2;
    logic [11:0] inst_offset;
    logic        full;
    logic [1:0]  wb_valid;
    logic [7:0]  wb_rob_id;
    logic [63:0] wb_value;
    logic        rob_empty;
    logic [3:0]  rob_head_id;
    logic        mem_valid, mem_wr;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [3:0]  out_rob_id;
    logic [31:0] out_value;

    int n_cmp = 0;
    int n_err = 0;

    load_store_queue #(.LSQ_SIZE_BIT(3), .ROB_BIT(4), .NUM_WB(2), .IO_TAG(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .inst_valid(inst_valid), .inst_type(inst_type), .inst_r1(inst_r1), .inst_r2(inst_r2),
        .inst_dep1(inst_dep1), .inst_dep2(inst_dep2),
        .inst_has_dep1(inst_has_dep1), .inst_has_dep2(inst_has_dep2),
        .inst_offset(inst_offset), .inst_rob_id(inst_rob_id), .full(full),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
        .rob_empty(rob_empty), .rob_head_id(rob_head_id),
        .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_rob_id(out_rob_id), .out_value(out_value)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic put(input logic st, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [11:0] off, input logic [3:0] rob,
                       input logic hd1, input logic [3:0] d1,
                       input logic hd2, input logic [3:0] d2);
        inst_valid    = 1'b1;
        inst_type     = {st, 3'b010};
        inst_r1       = r1;
        inst_r2       = r2;
        inst_offset   = off;
        inst_rob_id   = rob;
        inst_has_dep1 = hd1;
        inst_dep1     = d1;
        inst_has_dep2 = hd2;
        inst_dep2     = d2;
    endtask

    int          exp_rob [$];
    logic [31:0] exp_addr[$];
    int          allocs, done, cyc;
    logic [31:0] rd;

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        inst_valid = 1'b0; inst_type = '0; inst_r1 = '0; inst_r2 = '0;
        inst_dep1 = '0; inst_dep2 = '0; inst_has_dep1 = 1'b0; inst_has_dep2 = 1'b0;
        inst_offset = '0; inst_rob_id = '0;
        wb_valid = '0; wb_rob_id = '0; wb_value = '0;
        rob_empty = 1'b1; rob_head_id = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) tick();
        check("rst_full", full, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_size", mem_size, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_out_valid", out_valid, 0);
        rst_in = 1'b1;
        tick();

        // load r1=0x1000, offset -4
        put(0, 32'h1000, 32'h0, 12'hFFC, 4'd1, 0, 0, 0, 0);
        tick();
        inst_valid = 1'b0;
        check("ld_not_yet", mem_valid, 0);
        tick();
        check("ld_valid", mem_valid, 1);
        check("ld_addr", mem_addr, 32'h0000_0FFC);
        check("ld_wr", mem_wr, 0);
        check("ld_size", mem_size, 3'b010);
        rdy_in = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("rdy_low_no_out", out_valid, 0);
        tick();
        check("rdy_low_hold", mem_valid, 1);
        rdy_in = 1'b1;
        #1;
        check("ld_out_valid", out_valid, 1);
        check("ld_out_rob", out_rob_id, 1);
        check("ld_out_value", out_value, 32'hDEAD_BEEF);
        tick();
        mem_ready = 1'b0;
        check("ld_done_idle", mem_valid, 0);

        // store waits for ROB head
        rob_empty = 1'b0; rob_head_id = 4'd3;
        put(1, 32'h100, 32'hCAFE_F00D, 12'h008, 4'd5, 0, 0, 0, 0);
        tick();
        inst_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("st_wait_head", mem_valid, 0);
            tick();
        end
        rob_head_id = 4'd5;
        tick();
        check("st_valid", mem_valid, 1);
        check("st_wr", mem_wr, 1);
        check("st_addr", mem_addr, 32'h108);
        check("st_wdata", mem_wdata, 32'hCAFE_F00D);
        tick();
        check("st_hold_addr", mem_addr, 32'h108);
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        check("st_out_valid", out_valid, 1);
        check("st_out_rob", out_rob_id, 5);
        check("st_out_value", out_value, 0);
        tick();
        mem_ready = 1'b0;
        check("st_done_idle", mem_valid, 0);

        // I/O load also waits for ROB head
        rob_head_id = 4'd0;
        put(0, 32'h0003_0000, 32'h0, 12'h010, 4'd12, 0, 0, 0, 0);
        tick();
        inst_valid = 1'b0;
        tick();
        check("io_wait_head", mem_valid, 0);
        rob_head_id = 4'd12;
        tick();
        check("io_valid", mem_valid, 1);
        check("io_addr", mem_addr, 32'h0003_0010);
        mem_ready = 1'b1; mem_rdata = 32'h0000_00AB;
        #1;
        check("io_out_rob", out_rob_id, 12);
        tick();
        mem_ready = 1'b0;
        rob_empty = 1'b1;

        // wakeup in the allocation cycle on channel 1
        put(0, 32'h0000_BAD0, 32'h0, 12'h000, 4'd2, 1, 4'd7, 0, 0);
        wb_valid = 2'b10; wb_rob_id = {4'd7, 4'd0}; wb_value = {32'h2000, 32'h0};
        tick();
        inst_valid = 1'b0; wb_valid = 2'b00;
        check("wk0_not_yet", mem_valid, 0);
        tick();
        check("wk0_valid", mem_valid, 1);
        check("wk0_addr", mem_addr, 32'h2000);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;

        // wakeup one cycle after allocation, both channels at once
        put(0, 32'h0000_BAD0, 32'h0, 12'h000, 4'd3, 1, 4'd7, 1, 4'd4);
        tick();
        inst_valid = 1'b0;
        wb_valid = 2'b11; wb_rob_id = {4'd7, 4'd4}; wb_value = {32'h2000, 32'h0000_0055};
        check("wk1_pending", mem_valid, 0);
        tick();
        wb_valid = 2'b00;
        check("wk1_captured", mem_valid, 0);
        tick();
        check("wk1_valid", mem_valid, 1);
        check("wk1_addr", mem_addr, 32'h2000);
        check("wk1_wdata", mem_wdata, 32'h0000_0055);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;

        // back-to-back issue
        put(0, 32'h3000, 32'h0, 12'h000, 4'd8, 0, 0, 0, 0);
        tick();
        put(0, 32'h4000, 32'h0, 12'h000, 4'd9, 0, 0, 0, 0);
        tick();
        inst_valid = 1'b0;
        check("b2b_addr0", mem_addr, 32'h3000);
        mem_ready = 1'b1; mem_rdata = 32'h11;
        #1;
        check("b2b_rob0", out_rob_id, 8);
        tick();
        mem_ready = 1'b0;
        check("b2b_valid1", mem_valid, 1);
        check("b2b_addr1", mem_addr, 32'h4000);
        mem_ready = 1'b1; mem_rdata = 32'h22;
        #1;
        check("b2b_rob1", out_rob_id, 9);
        check("b2b_val1", out_value, 32'h22);
        tick();
        mem_ready = 1'b0;
        check("b2b_idle", mem_valid, 0);

        // flush during a load, with a second entry queued behind it
        put(0, 32'h5000, 32'h0, 12'h000, 4'd10, 0, 0, 0, 0);
        tick();
        put(0, 32'h6000, 32'h0, 12'h000, 4'd11, 0, 0, 0, 0);
        tick();
        inst_valid = 1'b0;
        check("fl_busy", mem_valid, 1);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check("fl_drain_valid", mem_valid, 1);
        check("fl_drain_addr", mem_addr, 32'h5000);
        mem_ready = 1'b1; mem_rdata = 32'h77;
        #1;
        check("fl_drain_no_out", out_valid, 0);
        tick();
        mem_ready = 1'b0;
        check("fl_idle", mem_valid, 0);
        check("fl_full", full, 0);
        tick();
        check("fl_no_stale_issue", mem_valid, 0);

        // fill with stores that cannot issue, then drain them in ROB order
        for (int k = 0; k < 7; k++) begin
            put(1, 32'h200 + 32'(k * 4), 32'h5000 + 32'(k), 12'h000, 4'(k), 0, 0, 0, 0);
            tick();
            check("fill_full", full, (k == 6) ? 1 : 0);
        end
        inst_valid = 1'b0;
        rob_empty = 1'b0;
        for (int k = 0; k < 7; k++) begin
            rob_head_id = 4'(k);
            tick();
            check("drain_valid", mem_valid, 1);
            check("drain_wdata", mem_wdata, 32'h5000 + 32'(k));
            mem_ready = 1'b1; mem_rdata = 32'hFFFF;
            #1;
            check("drain_rob", out_rob_id, 4'(k));
            tick();
            mem_ready = 1'b0;
            if (k == 0) check("drain_full_clear", full, 0);
        end
        rob_empty = 1'b1;

        // 20 loads streamed through the wrapping queue, memory answers immediately
        allocs = 0; done = 0; cyc = 0;
        while (done < 20 && cyc < 300) begin
            if (allocs < 20 && !full) begin
                put(0, 32'h100 * 32'(allocs + 1), 32'h0, 12'h004, 4'(allocs % 16), 0, 0, 0, 0);
                exp_rob.push_back(allocs % 16);
                exp_addr.push_back(32'h100 * 32'(allocs + 1) + 32'h4);
                allocs++;
            end else begin
                inst_valid = 1'b0;
            end
            mem_ready = mem_valid;
            if (mem_valid) begin
                if (exp_rob.size() == 0) begin
                    check("wrap_spurious", mem_valid, 0);
                end else begin
                    rd = exp_addr[0] ^ 32'hA5A5_0000;
                    mem_rdata = rd;
                    #1;
                    check("wrap_addr", mem_addr, exp_addr[0]);
                    check("wrap_out_valid", out_valid, 1);
                    check("wrap_rob", out_rob_id, exp_rob[0]);
                    check("wrap_value", out_value, rd);
                    void'(exp_rob.pop_front());
                    void'(exp_addr.pop_front());
                    done++;
                end
            end
            tick();
            cyc++;
        end
        inst_valid = 1'b0; mem_ready = 1'b0;
        check("wrap_done", done, 20);

        // asynchronous reset mid-transaction
        put(0, 32'h7000, 32'h0, 12'h000, 4'd6, 0, 0, 0, 0);
        tick();
        inst_valid = 1'b0;
        tick();
        check("arst_busy", mem_valid, 1);
        #2;
        rst_in = 1'b0;
        #1;
        check("arst_valid", mem_valid, 0);
        check("arst_addr", mem_addr, 0);
        rst_in = 1'b1;
        tick();
        tick();
        check("arst_no_reissue", mem_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
